// File: rtl/wb_regfile.sv
// wb_regfile: EX/MEM and MEM/WB result pipeline committing to a 32x32 register file with forwarded reads
//   clk, rst                       : clock, synchronous active-high reset
//   stall, flush                   : hold EX/MEM (bubble into MEM/WB) / bubble into EX/MEM
//   ex_wd_i, ex_wreg_i, ex_wdata_i : EX stage result
//   re*_i, raddr*_i, rdata*_o      : two combinational read ports with full forwarding
//   mem_*_o, wb_*_o                : EX/MEM and MEM/WB register contents
//   wb_count_o                     : committed-write counter
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [4:0]  ex_wd_i,
  input  logic        ex_wreg_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        re1_i,
  input  logic [4:0]  raddr1_i,
  input  logic        re2_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  output logic [4:0]  mem_wd_o,
  output logic        mem_wreg_o,
  output logic [31:0] mem_wdata_o,
  output logic [4:0]  wb_wd_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wdata_o,
  output logic [31:0] wb_count_o
);
  logic [31:0] regs [32];
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wd_o    <= '0;
      mem_wreg_o  <= 1'b0;
      mem_wdata_o <= '0;
      wb_wd_o     <= '0;
      wb_wreg_o   <= 1'b0;
      wb_wdata_o  <= '0;
      wb_count_o  <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (flush) begin
        mem_wd_o    <= '0;
        mem_wreg_o  <= 1'b0;
        mem_wdata_o <= '0;
        wb_wd_o     <= mem_wd_o;
        wb_wreg_o   <= mem_wreg_o;
        wb_wdata_o  <= mem_wdata_o;
      end else if (stall) begin
        wb_wd_o     <= '0;
        wb_wreg_o   <= 1'b0;
        wb_wdata_o  <= '0;
      end else begin
        mem_wd_o    <= ex_wd_i;
        mem_wreg_o  <= ex_wreg_i;
        mem_wdata_o <= ex_wdata_i;
        wb_wd_o     <= mem_wd_o;
        wb_wreg_o   <= mem_wreg_o;
        wb_wdata_o  <= mem_wdata_o;
      end
      // commit uses the pre-edge MEM/WB entry regardless of stall/flush
      if (wb_wreg_o && wb_wd_o != 5'd0) begin
        regs[wb_wd_o] <= wb_wdata_o;
        wb_count_o    <= wb_count_o + 32'd1;
      end
    end
  end
  // youngest producer wins: EX, then EX/MEM, then MEM/WB, then the array
  always_comb begin
    rdata1_o = (rst || !re1_i || raddr1_i == 5'd0) ? 32'd0 :
               (ex_wreg_i && ex_wd_i == raddr1_i) ? ex_wdata_i :
               (mem_wreg_o && mem_wd_o == raddr1_i) ? mem_wdata_o :
               (wb_wreg_o && wb_wd_o == raddr1_i) ? wb_wdata_o : regs[raddr1_i];
    rdata2_o = (rst || !re2_i || raddr2_i == 5'd0) ? 32'd0 :
               (ex_wreg_i && ex_wd_i == raddr2_i) ? ex_wdata_i :
               (mem_wreg_o && mem_wd_o == raddr2_i) ? mem_wdata_o :
               (wb_wreg_o && wb_wd_o == raddr2_i) ? wb_wdata_o : regs[raddr2_i];
  end
endmodule
